// File: rtl/demux_pkg.sv
// Shared types and constants for the round-robin / fixed steering demux.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package demux_pkg;

   localparam int NUM_CH = 8;
   localparam int CH_W   = 3;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   typedef struct packed {
      logic            vld;
      logic [CH_W-1:0] idx;
   } pick_t;

   // Rotate the enable mask so ptr lands on bit 0, take the lowest set bit,
   // then add ptr back (mod 8) to get the absolute channel index.
   function automatic pick_t rr_pick(input logic [NUM_CH-1:0] en,
                                     input logic [CH_W-1:0]   ptr);
      logic [2*NUM_CH-1:0] dbl;
      logic [NUM_CH-1:0]   rot;
      pick_t               res;
      dbl = {en, en} >> ptr;
      rot = dbl[NUM_CH-1:0];
      res = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (rot[i]) begin
            res.vld = 1'b1;
            res.idx = CH_W'(i) + ptr;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/onehot_dec3to8.sv
// 3-bit index to 8-bit one-hot decoder, all zeros when vld is low.
// Latency: combinational.
// Backpressure: none.
module onehot_dec3to8 (
   input  logic       vld,
   input  logic [2:0] idx,
   output logic [7:0] oh
);

   // Decode the index only while the qualifier is set.
   always_comb begin
      oh = 8'h00;
      if (vld) begin
         oh = 8'h01 << idx;
      end
   end

endmodule

// File: rtl/demux_rr_sched.sv
// One-word-deep demux steering an input stream to 8 channels, round-robin or fixed.
// Latency: 1 cycle from capture to out_valid; sustains one word per cycle.
// Backpressure: in_ready drops while the held word's channel is not ready or no target is enabled.
module demux_rr_sched
   import demux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             mode,
   input  logic [2:0]       fix_sel,
   input  logic [7:0]       ch_en,
   output logic [7:0]       out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic [7:0]       out_ready,
   output logic [2:0]       sel,
   output logic [15:0]      xfer_cnt
);

   state_e           state_q, state_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [2:0]       sel_q, sel_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [15:0]      cnt_q, cnt_d;

   pick_t tgt;
   logic  hs;
   logic  cap;
   logic  hold_vld;

   // Choose the target channel: fixed index if enabled, else next enabled from ptr.
   always_comb begin
      tgt = rr_pick(ch_en, ptr_q);
      if (mode) begin
         tgt.vld = ch_en[fix_sel];
         tgt.idx = fix_sel;
      end
   end

   // Handshake/accept decisions; in_ready is held low while reset is asserted.
   always_comb begin
      hold_vld = (state_q == HOLD);
      hs       = hold_vld && out_ready[sel_q];
      in_ready = rst_n && tgt.vld && (!hold_vld || hs);
      cap      = in_valid && in_ready;
   end

   // Next-state: capture wins over drain so back-to-back words stay in HOLD.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (hs) begin
         cnt_d = cnt_q + 16'd1;
      end
      if (cap) begin
         state_d = HOLD;
         sel_d   = tgt.idx;
         data_d  = in_data;
         if (!mode) begin
            ptr_d = tgt.idx + 3'd1;
         end
      end else if (hs) begin
         state_d = IDLE;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   onehot_dec3to8 u_ov_dec (
      .vld (hold_vld),
      .idx (sel_q),
      .oh  (out_valid)
   );

   assign out_data = data_q;
   assign sel      = sel_q;
   assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched: directed scenarios plus randomized traffic vs a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_demux_rr_sched;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       mode;
   logic [2:0] fix_sel;
   logic [7:0] ch_en;
   logic [7:0] out_valid;
   logic [7:0] out_data;
   logic [7:0] out_ready;
   logic [2:0] sel;
   logic [15:0] xfer_cnt;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   bit       m_hold;
   int       m_sel;
   int       m_ptr;
   int       m_cnt;
   int       m_data;
   bit       acc;

   // observed deliveries
   int dlv_ch[$];
   int dlv_dat[$];

   demux_rr_sched #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mode      (mode),
      .fix_sel   (fix_sel),
      .ch_en     (ch_en),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .sel       (sel),
      .xfer_cnt  (xfer_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic int m_target();
      if (mode) return ch_en[fix_sel] ? int'(fix_sel) : -1;
      for (int i = 0; i < 8; i++) begin
         if (ch_en[(m_ptr + i) % 8]) return (m_ptr + i) % 8;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_hold = 0;
      m_sel  = 0;
      m_ptr  = 0;
      m_cnt  = 0;
      m_data = 0;
      acc    = 0;
   endtask

   // Called at a falling edge with inputs already driven; checks, advances model, waits one cycle.
   task automatic cycle();
      int t;
      bit er;
      bit hs;
      bit cap;
      int ch;
      #1;
      t  = m_target();
      er = (t >= 0) && (!m_hold || out_ready[m_sel]);
      chk("in_ready", in_ready, er);
      chk("out_valid", out_valid, m_hold ? (32'd1 << m_sel) : 32'd0);
      chk("out_data", out_data, m_data);
      chk("sel", sel, m_sel);
      chk("xfer_cnt", xfer_cnt, m_cnt);
      if ((out_valid & out_ready) != 8'h00) begin
         ch = 0;
         for (int i = 0; i < 8; i++) if (out_valid[i]) ch = i;
         dlv_ch.push_back(ch);
         dlv_dat.push_back(int'(out_data));
      end
      hs  = m_hold && out_ready[m_sel];
      cap = in_valid && er;
      if (hs) m_cnt = (m_cnt + 1) % 65536;
      if (cap) begin
         m_hold = 1;
         m_data = int'(in_data);
         m_sel  = t;
         if (!mode) m_ptr = (t + 1) % 8;
      end else if (hs) begin
         m_hold = 0;
      end
      acc = cap;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dlv_ch.delete();
      dlv_dat.delete();
   endtask

   initial begin
      int w;
      int exp4[4];
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hAB;
      mode      = 1'b0;
      fix_sel   = 3'd0;
      ch_en     = 8'hFF;
      out_ready = 8'hFF;
      model_reset();

      // reset state
      #2;
      chk("init_in_ready", in_ready, 0);
      chk("init_out_valid", out_valid, 0);
      chk("init_sel", sel, 0);
      chk("init_xfer_cnt", xfer_cnt, 0);
      chk("init_out_data", out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // full-rate round robin over all channels
      do_reset();
      mode = 0; ch_en = 8'hFF; out_ready = 8'hFF;
      w = 0;
      for (int k = 0; k < 10; k++) begin
         in_valid = 1; in_data = 8'(w);
         cycle();
         if (acc) w++;
      end
      chk("rr_full_rate_words", w, 10);
      in_valid = 0;
      cycle();
      cycle();
      chk("rr_cnt10", xfer_cnt, 10);
      chk("rr_ndlv", dlv_ch.size(), 10);
      for (int k = 0; k < 10; k++) begin
         if (k < dlv_ch.size()) begin
            chk("rr_ch", dlv_ch[k], k % 8);
            chk("rr_dat", dlv_dat[k], k);
         end
      end

      // sparse mask, pointer wrap 7->0
      do_reset();
      mode = 0; ch_en = 8'b1000_0100; out_ready = 8'hFF;
      exp4 = '{2, 7, 2, 7};
      w = 0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1; in_data = 8'(8'h10 + w);
         cycle();
         if (acc) w++;
      end
      in_valid = 0;
      cycle();
      chk("sparse_ndlv", dlv_ch.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < dlv_ch.size()) chk("sparse_ch", dlv_ch[k], exp4[k]);
      end

      // fixed steering with stalled channel
      do_reset();
      mode = 1; fix_sel = 3'd5; ch_en = 8'hFF; out_ready = 8'h00;
      in_valid = 1; in_data = 8'h55;
      cycle();
      in_data = 8'h66;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("fix_rdy_low", in_ready, 0);
         chk("fix_ov_stable", out_valid, 8'h20);
         cycle();
      end
      out_ready = 8'h20; in_valid = 0;
      #1;
      chk("fix_ov_stable", out_valid, 8'h20);
      cycle();
      #1;
      chk("fix_ov_drained", out_valid, 0);
      cycle();
      chk("fix_ndlv", dlv_ch.size(), 1);
      if (dlv_ch.size() > 0) begin
         chk("fix_ch", dlv_ch[0], 5);
         chk("fix_dat", dlv_dat[0], 8'h55);
      end
      // fixed captures leave the round-robin pointer at 0
      mode = 0; ch_en = 8'hFF; out_ready = 8'hFF; in_valid = 1; in_data = 8'h01;
      cycle();
      in_valid = 0;
      cycle();
      if (dlv_ch.size() > 1) chk("fix_ptr_kept", dlv_ch[1], 0);
      else chk("fix_ptr_kept_ndlv", dlv_ch.size(), 2);

      // no enabled channel
      do_reset();
      mode = 0; ch_en = 8'h00; in_valid = 1; out_ready = 8'hFF;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("noen_rdy", in_ready, 0);
         chk("noen_ov", out_valid, 0);
         cycle();
      end
      mode = 1; fix_sel = 3'd2; ch_en = 8'hFB;
      #1;
      chk("fix_dis_rdy", in_ready, 0);
      cycle();

      // held word survives disable of its channel; other ready bits ignored
      do_reset();
      mode = 1; fix_sel = 3'd3; ch_en = 8'hFF; out_ready = 8'h00;
      in_valid = 1; in_data = 8'hA3;
      cycle();
      ch_en = 8'hF7; mode = 0; fix_sel = 3'd6; out_ready = 8'hF7;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("hold_ov", out_valid, 8'h08);
         cycle();
      end
      out_ready = 8'h08; in_valid = 0;
      cycle();
      chk("hold_ndlv", dlv_ch.size(), 1);
      if (dlv_ch.size() > 0) begin
         chk("hold_ch", dlv_ch[0], 3);
         chk("hold_dat", dlv_dat[0], 8'hA3);
      end

      // reset in the middle of HOLD
      do_reset();
      mode = 0; ch_en = 8'hFF; out_ready = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1; in_data = 8'(8'h30 + k);
         cycle();
      end
      out_ready = 8'h00; in_valid = 1; in_data = 8'h77;
      cycle();
      rst_n = 1'b0;
      #1;
      chk("midrst_ov", out_valid, 0);
      chk("midrst_cnt", xfer_cnt, 0);
      chk("midrst_rdy", in_ready, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      dlv_ch.delete();
      dlv_dat.delete();
      ch_en = 8'b1000_0010; out_ready = 8'hFF; in_valid = 1; in_data = 8'h42;
      cycle();
      in_valid = 0;
      cycle();
      chk("postrst_ndlv", dlv_ch.size(), 1);
      if (dlv_ch.size() > 0) begin
         chk("postrst_ch", dlv_ch[0], 1);
         chk("postrst_dat", dlv_dat[0], 8'h42);
      end

      // randomized traffic against the model
      do_reset();
      for (int k = 0; k < 800; k++) begin
         int r;
         if ($urandom_range(0, 79) == 0) do_reset();
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = 8'($urandom);
         mode     = ($urandom_range(0, 3) == 0);
         fix_sel  = 3'($urandom);
         r = int'($urandom_range(0, 7));
         if (r == 0) ch_en = 8'h00;
         else if (r == 1) ch_en = 8'hFF;
         else if (r < 5) ch_en = 8'($urandom);
         out_ready = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
